// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the micro-op input handshake and the imem write handshake of the
// instruction encoder.
//   in_valid/in_ready : micro-op handshake (producer -> encoder)
//   in_kind, in_alusel, in_rd, in_rs1, in_rs2, in_imm : decoded micro-op fields
//   mem_we/mem_ready  : imem write handshake (encoder -> memory)
//   mem_addr, mem_wdata : imem word address and instruction word
// Modports: master = environment side (producer + memory), slave = encoder.
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_alusel;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [19:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_kind, in_alusel, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_alusel, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Re-encodes decoded micro-op fields into RV32I instruction words, queues them
// in a DEPTH-entry FIFO and writes them to consecutive imem word addresses.
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   flush   : synchronous restart (clears FIFO, address, count and flags)
//   bus     : instr_encoder_if.slave (micro-op handshake + imem write port)
//   count   : words written since reset/flush, saturating
//   err     : sticky, an illegal kind/alusel was accepted
//   wrapped : sticky, the write address wrapped past its top value
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              wrapped
);
    localparam int                PW   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // Returns {legal, word}; word is only meaningful when legal is set.
    function automatic logic [32:0] encode_uop(
        input logic [2:0]  kind,
        input logic [2:0]  alusel,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic        ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        ok = 1'b1;
        f3 = 3'b000;
        f7 = 7'b0000000;
        w  = 32'h0000_0000;
        case (kind)
            3'd0: begin
                case (alusel)
                    3'b000:  begin f3 = 3'b000; f7 = 7'b0000000; end
                    3'b010:  begin f3 = 3'b000; f7 = 7'b0100000; end
                    3'b100:  begin f3 = 3'b001; f7 = 7'b0000000; end
                    3'b110:  begin f3 = 3'b100; f7 = 7'b0000000; end
                    3'b101:  begin f3 = 3'b101; f7 = 7'b0000000; end
                    3'b011:  begin f3 = 3'b101; f7 = 7'b0100000; end
                    3'b111:  begin f3 = 3'b111; f7 = 7'b0000000; end
                    default: ok = 1'b0;
                endcase
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            3'd1:    w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            3'd2:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            3'd3:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            // imm arrives in decode order: imm[10] is the B-type bit 11 slot.
            3'd4:    w = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
            3'd5:    w = 32'h0000_0013;
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    logic [31:0]       mem_q [DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              wrapped_q, wrapped_d;

    logic              empty_s, full_s, accept_s, push_s, pop_s, legal_s;
    logic [31:0]       enc_s;
    logic              unused_imm_s;

    assign unused_imm_s = ^bus.in_imm[19:12];

    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign {legal_s, enc_s} = encode_uop(bus.in_kind, bus.in_alusel, bus.in_rd,
                                         bus.in_rs1, bus.in_rs2, bus.in_imm[11:0]);

    // rst_n gates in_ready so nothing is offered as accepted while in reset.
    assign bus.in_ready  = rst_n && !full_s && !flush;
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign push_s        = accept_s && legal_s;
    assign pop_s         = !empty_s && bus.mem_ready && !flush;

    assign bus.mem_we    = !empty_s;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = empty_s ? 32'h0000_0000 : mem_q[rd_ptr_q[PW-1:0]];
    assign count         = count_q;
    assign err           = err_q;
    assign wrapped       = wrapped_q;

    // Next-state logic for pointers, address, counter and sticky flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        addr_d    = addr_q;
        count_d   = count_q;
        err_d     = err_q;
        wrapped_d = wrapped_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            addr_d    = BASE;
            count_d   = '0;
            err_d     = 1'b0;
            wrapped_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (accept_s && !legal_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + (PW+1)'(1);
                addr_d   = addr_q + ADDR_W'(1);
                if (addr_q == {ADDR_W{1'b1}}) begin
                    wrapped_d = 1'b1;
                end else begin
                    wrapped_d = wrapped_q;
                end
                if (count_q != {(ADDR_W+1){1'b1}}) begin
                    count_d = count_q + (ADDR_W+1)'(1);
                end else begin
                    count_d = count_q;
                end
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            addr_q    <= BASE;
            count_q   <= '0;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wrapped_q <= wrapped_d;
        end
    end

    // FIFO storage; written only on a legal accepted micro-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[PW-1:0]] <= enc_s;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench: directed scenarios plus randomized micro-op streams,
// checked every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int BASE   = 0;
    localparam int AMOD   = 1 << ADDR_W;
    localparam int CMAX   = (1 << (ADDR_W + 1)) - 1;
    localparam int F3_TAB [8] = '{0, 0, 0, 5, 1, 5, 4, 7};
    localparam int F7_TAB [8] = '{0, 0, 32, 32, 0, 0, 0, 0};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [ADDR_W:0] count;
    logic            err, wrapped;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .count   (count),
        .err     (err),
        .wrapped (wrapped)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    int          m_addr   = BASE;
    int          m_pops   = 0;
    bit          m_err    = 1'b0;
    bit          m_wrapped = 1'b0;
    logic [31:0] wlog_data [$];
    int          wlog_addr [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instruction word built from the field rules with plain arithmetic.
    function automatic void ref_encode(input longint kind, alusel, rd, rs1, rs2, imm,
                                       output bit legal, output logic [31:0] word);
        longint w;
        longint lo12;
        legal = 1'b1;
        w     = 0;
        lo12  = imm % 4096;
        case (kind)
            0: if (alusel == 1) legal = 1'b0;
               else w = F7_TAB[alusel] * (2**25) + rs2 * (2**20) + rs1 * (2**15)
                        + F3_TAB[alusel] * (2**12) + rd * (2**7) + 51;
            1: w = lo12 * (2**20) + rs1 * (2**15) + rd * (2**7) + 19;
            2: w = lo12 * (2**20) + rs1 * (2**15) + 2 * (2**12) + rd * (2**7) + 3;
            3: w = (lo12 / 32) * (2**25) + rs2 * (2**20) + rs1 * (2**15) + 2 * (2**12)
                   + (lo12 % 32) * (2**7) + 35;
            4: w = ((lo12 / 2048) % 2) * longint'(2**31) + ((lo12 / 16) % 64) * (2**25)
                   + rs2 * (2**20) + rs1 * (2**15) + (lo12 % 16) * (2**8)
                   + ((lo12 / 1024) % 2) * (2**7) + 99;
            5: w = 19;
            default: legal = 1'b0;
        endcase
        word = w[31:0];
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_addr    = BASE;
        m_pops    = 0;
        m_err     = 1'b0;
        m_wrapped = 1'b0;
    endfunction

    // One clock cycle: drive at negedge, check outputs, advance model past posedge.
    task automatic step(input bit v, input int kind, input int alusel, input int rd,
                        input int rs1, input int rs2, input int imm, input bit mr, input bit fl);
        bit          exp_rdy, exp_we, push, pop, legal;
        logic [31:0] word;
        bus.in_valid  = v;
        bus.in_kind   = 3'(kind);
        bus.in_alusel = 3'(alusel);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_imm    = 20'(imm);
        bus.mem_ready = mr;
        flush         = fl;
        #1;
        exp_rdy = (exp_q.size() < DEPTH) && !fl;
        exp_we  = (exp_q.size() != 0);
        check_eq("in_ready",  bus.in_ready, exp_rdy);
        check_eq("mem_we",    bus.mem_we, exp_we);
        check_eq("mem_wdata", bus.mem_wdata, exp_we ? exp_q[0] : 32'h0);
        check_eq("mem_addr",  bus.mem_addr, m_addr);
        check_eq("count",     count, (m_pops > CMAX) ? CMAX : m_pops);
        check_eq("err",       err, m_err);
        check_eq("wrapped",   wrapped, m_wrapped);
        push = v && exp_rdy;
        pop  = exp_we && mr && !fl;
        if (pop) begin
            wlog_data.push_back(bus.mem_wdata);
            wlog_addr.push_back(int'(bus.mem_addr));
        end
        ref_encode(kind, alusel, rd, rs1, rs2, imm, legal, word);
        @(posedge clk);
        @(negedge clk);
        if (fl) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                if (m_addr == AMOD - 1) m_wrapped = 1'b1;
                m_addr = (m_addr + 1) % AMOD;
                m_pops++;
            end
            if (push) begin
                if (legal) exp_q.push_back(word);
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit mr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0, mr, 1'b0);
    endtask

    task automatic rand_step(input int flush_pct);
        int k;
        k = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        step($urandom_range(0, 99) < 95, k, $urandom_range(0, 7), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, (1 << 20) - 1),
             $urandom_range(0, 99) < 90, $urandom_range(0, 99) < flush_pct);
    endtask

    initial begin
        int n0;
        bus.in_valid = 1'b0; bus.in_kind = 3'd0; bus.in_alusel = 3'd0;
        bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
        bus.in_imm = 20'd0; bus.mem_ready = 1'b0;

        // Reset state while rst_n is held low.
        @(negedge clk);
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1'b0);
        check_eq("rst_mem_we",   bus.mem_we, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, BASE);
        check_eq("rst_wdata",    bus.mem_wdata, 32'h0);
        check_eq("rst_count",    count, 0);
        check_eq("rst_err",      err, 1'b0);
        check_eq("rst_wrapped",  wrapped, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // add x3,x1,x2 ; sub x5,x6,x7
        step(1'b1, 0, 0, 3, 1, 2, 0, 1'b1, 1'b0);
        step(1'b1, 0, 2, 5, 6, 7, 0, 1'b1, 1'b0);
        idle(1'b1, 3);
        check_eq("add_word", wlog_data[0], 32'h002081B3);
        check_eq("add_addr", wlog_addr[0], 0);
        check_eq("sub_word", wlog_data[1], 32'h407302B3);
        check_eq("sub_addr", wlog_addr[1], 1);
        check_eq("count_two", count, 2);

        // addi x1,x0,5 ; lw x4,4(x1) ; sw x2,8(x1)
        step(1'b1, 1, 0, 1, 0, 0, 5, 1'b1, 1'b0);
        step(1'b1, 2, 0, 4, 1, 0, 4, 1'b1, 1'b0);
        step(1'b1, 3, 0, 0, 1, 2, 8, 1'b1, 1'b0);
        idle(1'b1, 3);
        check_eq("addi_word", wlog_data[2], 32'h00500093);
        check_eq("lw_word",   wlog_data[3], 32'h0040A203);
        check_eq("sw_word",   wlog_data[4], 32'h0020A423);
        check_eq("sw_addr",   wlog_addr[4], 4);

        // Stall: 5 NOPs with memory not ready, only 4 fit.
        n0 = wlog_data.size();
        for (int i = 0; i < 4; i++) step(1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check_eq("full_ready", bus.in_ready, 1'b0);
        step(1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 6);
        check_eq("stall_writes", wlog_data.size() - n0, 4);
        for (int i = n0; i < wlog_data.size(); i++) check_eq("stall_nop", wlog_data[i], 32'h00000013);

        // Illegal kinds: kind 7, R alusel 001, then add x1,x2,x3.
        step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        n0 = wlog_data.size();
        step(1'b1, 7, 0, 1, 2, 3, 0, 1'b1, 1'b0);
        step(1'b1, 0, 1, 1, 2, 3, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 1, 2, 3, 0, 1'b1, 1'b0);
        idle(1'b1, 3);
        check_eq("ill_err",    err, 1'b1);
        check_eq("ill_writes", wlog_data.size() - n0, 1);
        check_eq("ill_word",   wlog_data[n0], 32'h003100B3);
        check_eq("ill_addr",   wlog_addr[n0], BASE);

        // Flush with 3 queued words and input offered on the flush cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 5, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        #1;
        check_eq("fl_mem_we", bus.mem_we, 1'b0);
        check_eq("fl_addr",   bus.mem_addr, BASE);
        check_eq("fl_count",  count, 0);
        check_eq("fl_err",    err, 1'b0);
        idle(1'b1, 2);

        // Long random stream: address wrap and count saturation.
        for (int i = 0; i < 3000; i++) rand_step(0);
        idle(1'b1, 6);
        check_eq("wrap_flag", wrapped, m_pops >= AMOD);
        check_eq("wrap_seen", wrapped, 1'b1);
        if (m_pops >= CMAX) check_eq("count_sat", count, CMAX);

        // Random stream with occasional flushes.
        for (int i = 0; i < 400; i++) rand_step(2);

        // Asynchronous reset mid-stream discards the FIFO immediately.
        for (int i = 0; i < 3; i++) step(1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_mem_we", bus.mem_we, 1'b0);
        check_eq("arst_ready",  bus.in_ready, 1'b0);
        check_eq("arst_count",  count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(1'b1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
